// File: rtl/g11620_scan_sched_pkg.sv
// Shared definitions for the G11620 scan scheduler.
// Contents: config-RAM register addresses, CTRL bit positions, and a CTRL decode helper.
package g11620_scan_sched_pkg;

    localparam logic [7:0] G11620_CTRL_R_ADDR  = 8'd0;
    localparam logic [7:0] G11620_INTEG_R_ADDR = 8'd1;
    localparam logic [7:0] G11620_STP_R_ADDR   = 8'd2;
    localparam logic [7:0] G11620_SCAN_R_ADDR  = 8'd4;

    localparam int unsigned G11620_CTRL_EN_BIT   = 0;
    localparam int unsigned G11620_CTRL_CONT_BIT = 1;

    typedef struct packed {
        logic en;
        logic cont;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input logic [31:0] word);
        ctrl_t c;
        c.en   = word[G11620_CTRL_EN_BIT];
        c.cont = word[G11620_CTRL_CONT_BIT];
        return c;
    endfunction

endpackage

// File: rtl/g11620_cfg_rd.sv
// One-shot config-RAM reader.
// Ports: clk/rst_n clock and async active-low reset; i_start launches a read of i_addr;
//        i_clr drops any read in flight; o_rd/o_addr drive the RAM for one cycle;
//        i_din is sampled RAM_LAT cycles after o_rd and returned on o_data with a 1-cycle o_valid.
module g11620_cfg_rd #(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_clr,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_din,
    output logic        o_rd,
    output logic [7:0]  o_addr,
    output logic [31:0] o_data,
    output logic        o_valid
);

    localparam int unsigned LatW = $clog2(RAM_LAT + 1);
    localparam logic [LatW-1:0] LatMax = LatW'(RAM_LAT);
    localparam logic [LatW-1:0] LatOne = LatW'(1);

    logic            r_rd;
    logic [7:0]      r_addr;
    logic            r_pend;
    logic [LatW-1:0] r_lat;
    logic [31:0]     r_data;
    logic            r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= 1'b0;
            r_addr  <= 8'd0;
            r_pend  <= 1'b0;
            r_lat   <= '0;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // A new request outranks a clear so a trigger accepted in IDLE still launches.
            if (i_start) begin
                r_rd   <= 1'b1;
                r_addr <= i_addr;
                r_pend <= 1'b0;
            end else if (i_clr) begin
                r_rd   <= 1'b0;
                r_pend <= 1'b0;
            end else begin
                r_rd <= 1'b0;
                if (r_rd) begin
                    r_pend <= 1'b1;
                    r_lat  <= LatOne;
                end else if (r_pend) begin
                    if (r_lat == LatMax) begin
                        r_data  <= i_din;
                        r_valid <= 1'b1;
                        r_pend  <= 1'b0;
                    end else begin
                        r_lat <= r_lat + LatOne;
                    end
                end
            end
        end
    end

    assign o_rd    = r_rd;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/g11620_scan_sched.sv
// G11620 scan scheduler: on a host trigger loads CTRL/SCAN/STP from config RAM, issues one
// sensor start per scan, waits for sensor done (with optional timeout), spaces scans by STP.
// Ports: clk, rst_n (async active-low); trig_in (rising edge), abort_in (level);
//        sns_start_o / sns_soft_rst_o pulses and sns_done_i (rising edge) to/from sensor ctrl;
//        sns_ram_rd_i/sns_ram_addr_i forwarded (registered) to cfg_ram_rd_o/cfg_ram_addr_o
//        except while loading; cfg_ram_din read data; busy_o, scan_cnt_o, run_done_o, err_o status.
module g11620_scan_sched
    import g11620_scan_sched_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1,
    parameter logic [31:0] TIMEOUT = 32'd2000000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             abort_in,
    output logic             sns_start_o,
    output logic             sns_soft_rst_o,
    input  logic             sns_done_i,
    input  logic             sns_ram_rd_i,
    input  logic [7:0]       sns_ram_addr_i,
    output logic             cfg_ram_rd_o,
    output logic [7:0]       cfg_ram_addr_o,
    input  logic [31:0]      cfg_ram_din,
    output logic             busy_o,
    output logic [CNT_W-1:0] scan_cnt_o,
    output logic             run_done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StIdle, StLdCtrl, StLdScan, StLdStp, StStart, StWaitDone, StGap, StFinish
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state, w_state_nxt;
    logic             r_trig_d, r_done_d;
    logic             r_cont;
    logic [CNT_W-1:0] r_scan, r_cnt;
    logic [31:0]      r_stp, r_timer;
    logic             r_err, r_soft_rst;
    logic             r_sns_rd;
    logic [7:0]       r_sns_addr;

    logic             w_trig_rise, w_done_rise, w_in_ld, w_timer_stop, w_gap_end;
    logic             w_rd_start, w_accept, w_fail;
    logic [7:0]       w_rd_addr;
    logic             w_ld_rd, w_ld_valid;
    logic [7:0]       w_ld_addr;
    logic [31:0]      w_ld_data;
    logic [CNT_W:0]   w_cnt_inc;
    ctrl_t            w_ctrl;

    assign w_trig_rise  = trig_in & ~r_trig_d;
    assign w_done_rise  = sns_done_i & ~r_done_d;
    assign w_in_ld      = (r_state == StLdCtrl) || (r_state == StLdScan) || (r_state == StLdStp);
    assign w_cnt_inc    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_ctrl       = ctrl_decode(w_ld_data);
    assign w_timer_stop = (r_timer == 32'hFFFF_FFFF) ||
                          ((TIMEOUT != 32'd0) && (r_timer == TIMEOUT));
    // Timer is cleared on GAP entry, so exiting at STP-1 gives STP gap cycles (min one).
    assign w_gap_end    = (r_stp == 32'd0) || (r_timer >= r_stp - 32'd1);

    g11620_cfg_rd #(
        .RAM_LAT (RAM_LAT)
    ) u_cfg_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_rd_start),
        .i_clr   (r_state == StIdle),
        .i_addr  (w_rd_addr),
        .i_din   (cfg_ram_din),
        .o_rd    (w_ld_rd),
        .o_addr  (w_ld_addr),
        .o_data  (w_ld_data),
        .o_valid (w_ld_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_start  = 1'b0;
        w_rd_addr   = G11620_CTRL_R_ADDR;
        w_accept    = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_trig_rise) begin
                    w_state_nxt = StLdCtrl;
                    w_accept    = 1'b1;
                    w_rd_start  = 1'b1;
                end
            end
            StLdCtrl: begin
                if (w_ld_valid) begin
                    if (w_ctrl.en) begin
                        w_state_nxt = StLdScan;
                        w_rd_start  = 1'b1;
                        w_rd_addr   = G11620_SCAN_R_ADDR;
                    end else begin
                        w_state_nxt = StFinish;
                    end
                end
            end
            StLdScan: begin
                if (w_ld_valid) begin
                    if ((w_ld_data == 32'd0) && !r_cont) begin
                        w_state_nxt = StFinish;
                    end else begin
                        w_state_nxt = StLdStp;
                        w_rd_start  = 1'b1;
                        w_rd_addr   = G11620_STP_R_ADDR;
                    end
                end
            end
            StLdStp: begin
                if (w_ld_valid) w_state_nxt = StStart;
            end
            StStart: w_state_nxt = StWaitDone;
            StWaitDone: begin
                // A done arriving on the timeout cycle still counts as a completed scan.
                if (w_done_rise) begin
                    w_state_nxt = (r_cont || (w_cnt_inc < {1'b0, r_scan})) ? StGap : StFinish;
                end else if ((TIMEOUT != 32'd0) && (r_timer == TIMEOUT)) begin
                    w_state_nxt = StIdle;
                    w_fail      = 1'b1;
                end
            end
            StGap: begin
                if (w_gap_end) w_state_nxt = StStart;
            end
            StFinish: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
        if ((r_state != StIdle) && abort_in) begin
            w_state_nxt = StIdle;
            w_fail      = 1'b1;
            w_rd_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_d   <= 1'b0;
            r_done_d   <= 1'b0;
            r_cont     <= 1'b0;
            r_scan     <= '0;
            r_stp      <= 32'd0;
            r_timer    <= 32'd0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_soft_rst <= 1'b0;
            r_sns_rd   <= 1'b0;
            r_sns_addr <= 8'd0;
        end else begin
            r_trig_d   <= trig_in;
            r_done_d   <= sns_done_i;
            r_sns_rd   <= sns_ram_rd_i;
            r_sns_addr <= sns_ram_addr_i;
            r_soft_rst <= w_fail;

            if (w_accept) begin
                r_err <= 1'b0;
                r_cnt <= '0;
            end else if (w_fail) begin
                r_err <= 1'b1;
            end

            if (w_ld_valid && (r_state == StLdCtrl)) r_cont <= w_ctrl.cont;
            if (w_ld_valid && (r_state == StLdScan)) r_scan <= w_ld_data[CNT_W-1:0];
            if (w_ld_valid && (r_state == StLdStp))  r_stp  <= w_ld_data;

            if ((r_state == StWaitDone) && w_done_rise && !abort_in) begin
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CntOne;
            end

            if (r_state == StStart) begin
                r_timer <= 32'd0;
            end else if (r_state == StWaitDone) begin
                if (w_done_rise)        r_timer <= 32'd0;
                else if (!w_timer_stop) r_timer <= r_timer + 32'd1;
            end else if (r_state == StGap) begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    assign sns_start_o    = (r_state == StStart);
    assign sns_soft_rst_o = r_soft_rst;
    assign busy_o         = (r_state != StIdle);
    assign run_done_o     = (r_state == StFinish);
    assign err_o          = r_err;
    assign scan_cnt_o     = r_cnt;
    assign cfg_ram_rd_o   = w_in_ld ? w_ld_rd   : r_sns_rd;
    assign cfg_ram_addr_o = w_in_ld ? w_ld_addr : r_sns_addr;

endmodule
